// File: rtl/fmul_share_arbiter.sv
// Shares one fixed-latency pipelined fmul among NREQ requesters with owner-tag steering.
// Define FMUL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.

module fmul_share_slot (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_accept,
  input  logic        i_wb,
  input  logic [31:0] i_result,
  input  logic        i_rsp_ready,
  output logic        o_busy,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_result
);
  logic        r_busy;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_result;
  logic        w_pop;

  assign w_pop = r_rsp_valid & i_rsp_ready;

  // busy spans accept through response pop, so a slot never holds two ops
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy       <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
    end else begin
      if (i_accept)   r_busy <= 1'b1;
      else if (w_pop) r_busy <= 1'b0;
      if (i_wb) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_result <= i_result;
      end else if (w_pop) begin
        r_rsp_valid  <= 1'b0;
      end
    end
  end

  assign o_busy       = r_busy;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_rsp_result;
endmodule

module fmul_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NREQ-1:0]   i_req_valid,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic [NREQ*32-1:0] i_req_op1,
  input  logic [NREQ*32-1:0] i_req_op2,
  output logic [NREQ-1:0]   o_rsp_valid,
  input  logic [NREQ-1:0]   i_rsp_ready,
  output logic [NREQ*32-1:0] o_rsp_result,
  output logic [31:0]       o_fmul_op1,
  output logic [31:0]       o_fmul_op2,
  input  logic [31:0]       i_fmul_result
);
  localparam int TAGW = $clog2(NREQ);

  logic [NREQ-1:0][31:0]        w_op1, w_op2, w_rsp_result;
  logic [NREQ-1:0]              w_busy, w_elig, w_rot, w_grant, w_wb;
  logic [2*NREQ-1:0]            w_dbl;
  logic [TAGW-1:0]              w_start, w_off, w_win, w_nxt;
  logic [TAGW:0]                w_sum;
  logic                         w_any, w_accept;
  logic [TAGW-1:0]              r_rr_ptr;
  logic [31:0]                  r_fmul_op1, r_fmul_op2;
  logic [LATENCY-1:0]           r_vld_pipe;
  logic [LATENCY-1:0][TAGW-1:0] r_tag_pipe;

  assign w_op1  = i_req_op1;
  assign w_op2  = i_req_op2;
  assign w_elig = i_req_valid & ~w_busy;

`ifdef FMUL_ARB_FIXED_PRIO_EN
  assign w_start = '0;
`else
  assign w_start = r_rr_ptr;
`endif

  // Rotate eligibility so the search start sits at bit 0, pick lowest, rotate back
  always_comb begin
    w_dbl   = {w_elig, w_elig} >> w_start;
    w_rot   = w_dbl[NREQ-1:0];
    w_off   = '0;
    w_any   = 1'b0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = TAGW'(k);
        w_any = 1'b1;
      end
    end
    w_sum   = {1'b0, w_start} + {1'b0, w_off};
    w_win   = (w_sum >= (TAGW+1)'(NREQ)) ? TAGW'(w_sum - (TAGW+1)'(NREQ)) : w_sum[TAGW-1:0];
    w_nxt   = ({1'b0, w_win} + (TAGW+1)'(1) == (TAGW+1)'(NREQ)) ? '0 : w_win + TAGW'(1);
    w_grant = (w_any && !i_reset) ? (NREQ'(1) << w_win) : '0;
  end

  assign w_accept    = |w_grant;
  assign o_req_ready = w_grant;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rr_ptr   <= '0;
      r_fmul_op1 <= '0;
      r_fmul_op2 <= '0;
      r_vld_pipe <= '0;
      r_tag_pipe <= '0;
    end else begin
`ifdef FMUL_ARB_FIXED_PRIO_EN
      r_rr_ptr <= '0;
`else
      if (w_accept) r_rr_ptr <= w_nxt;
`endif
      if (w_accept) begin
        r_fmul_op1 <= w_op1[w_win];
        r_fmul_op2 <= w_op2[w_win];
      end
      r_vld_pipe[0] <= w_accept;
      r_tag_pipe[0] <= w_win;
      for (int s = 1; s < LATENCY; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_tag_pipe[s] <= r_tag_pipe[s-1];
      end
    end
  end

  assign o_fmul_op1 = r_fmul_op1;
  assign o_fmul_op2 = r_fmul_op2;

  // Pipe tail lines up with the fmul result for the op issued LATENCY cycles earlier
  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    assign w_wb[g] = r_vld_pipe[LATENCY-1] && (r_tag_pipe[LATENCY-1] == TAGW'(g));
    fmul_share_slot u_slot (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_accept     (w_grant[g]),
      .i_wb         (w_wb[g]),
      .i_result     (i_fmul_result),
      .i_rsp_ready  (i_rsp_ready[g]),
      .o_busy       (w_busy[g]),
      .o_rsp_valid  (o_rsp_valid[g]),
      .o_rsp_result (w_rsp_result[g])
    );
  end

  assign o_rsp_result = w_rsp_result;
endmodule
